// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one-cycle pipeline stage register with flush/stall bubble control
// Optional stall/flush performance counters are built when PIPE_STAGE_PERF_CNT_EN is defined.
module pipe_stage_reg #(
   parameter int N_WORDS     = 7,
   parameter int TNEW_W      = 3,
   parameter int BUBBLE_TNEW = 0,
   parameter int CNT_W       = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    flush,
   input  logic                    valid_i,
   input  logic [31:0]             instr_i,
   input  logic [32*N_WORDS-1:0]   payload_i,
   input  logic                    newjudge_i,
   input  logic [TNEW_W-1:0]       tnew_i,
   input  logic                    cnt_clr,
   output logic                    valid_o,
   output logic [31:0]             instr_o,
   output logic [32*N_WORDS-1:0]   payload_o,
   output logic                    newjudge_o,
   output logic [TNEW_W-1:0]       tnew_o,
   output logic [CNT_W-1:0]        stall_cnt_o,
   output logic [CNT_W-1:0]        flush_cnt_o
);

   localparam logic [TNEW_W-1:0] BUBBLE_TNEW_V = TNEW_W'(BUBBLE_TNEW);

   logic                  valid_q,    valid_d;
   logic [31:0]           instr_q,    instr_d;
   logic [32*N_WORDS-1:0] payload_q,  payload_d;
   logic                  newjudge_q, newjudge_d;
   logic [TNEW_W-1:0]     tnew_q,     tnew_d;

   logic load_bubble;
   logic load_real;
   logic [TNEW_W-1:0] tnew_dec;

   // Flush wins over enable; an enabled load of an empty slot is the same as a flush.
   assign load_bubble = flush | (en & ~valid_i);
   assign load_real   = ~flush & en & valid_i;
   assign tnew_dec    = (tnew_i != '0) ? (tnew_i - TNEW_W'(1)) : '0;

   always_comb begin
      valid_d    = valid_q;
      instr_d    = instr_q;
      payload_d  = payload_q;
      newjudge_d = newjudge_q;
      tnew_d     = tnew_q;
      if (load_bubble) begin
         valid_d    = 1'b0;
         instr_d    = '0;
         payload_d  = '0;
         newjudge_d = 1'b0;
         tnew_d     = BUBBLE_TNEW_V;
      end else if (load_real) begin
         valid_d    = 1'b1;
         instr_d    = instr_i;
         payload_d  = payload_i;
         newjudge_d = newjudge_i;
         tnew_d     = tnew_dec;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q    <= 1'b0;
         instr_q    <= '0;
         payload_q  <= '0;
         newjudge_q <= 1'b0;
         tnew_q     <= BUBBLE_TNEW_V;
      end else begin
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         payload_q  <= payload_d;
         newjudge_q <= newjudge_d;
         tnew_q     <= tnew_d;
      end
   end

   assign valid_o    = valid_q;
   assign instr_o    = instr_q;
   assign payload_o  = payload_q;
   assign newjudge_o = newjudge_q;
   assign tnew_o     = tnew_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             stall_evt;
   logic             flush_evt;

   // A stall only counts when it is holding a real instruction; a flush only when it kills one.
   assign stall_evt = ~flush & ~en & valid_q;
   assign flush_evt = flush & (valid_i | valid_q);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_evt && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (flush_evt && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign stall_cnt_o    = '0;
   assign flush_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg against a behavioural model
module tb_pipe_stage_reg;

   localparam int N_WORDS = 7;
   localparam int TNEW_W  = 3;
   localparam int PW      = 32 * N_WORDS;
   localparam int BT_A    = 0;
   localparam int BT_B    = 5;
`ifdef PIPE_STAGE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              en = 1'b0;
   logic              flush = 1'b0;
   logic              valid_i = 1'b0;
   logic [31:0]       instr_i = '0;
   logic [PW-1:0]     payload_i = '0;
   logic              newjudge_i = 1'b0;
   logic [TNEW_W-1:0] tnew_i = '0;
   logic              cnt_clr = 1'b0;

   logic              a_valid, b_valid;
   logic [31:0]       a_instr, b_instr;
   logic [PW-1:0]     a_payload, b_payload;
   logic              a_nj, b_nj;
   logic [TNEW_W-1:0] a_tnew, b_tnew;
   logic [15:0]       a_stall, a_flush;
   logic [3:0]        b_stall, b_flush;

   pipe_stage_reg #(.N_WORDS(N_WORDS), .TNEW_W(TNEW_W), .BUBBLE_TNEW(BT_A), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i),
      .instr_i(instr_i), .payload_i(payload_i), .newjudge_i(newjudge_i),
      .tnew_i(tnew_i), .cnt_clr(cnt_clr),
      .valid_o(a_valid), .instr_o(a_instr), .payload_o(a_payload),
      .newjudge_o(a_nj), .tnew_o(a_tnew), .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
   );

   pipe_stage_reg #(.N_WORDS(N_WORDS), .TNEW_W(TNEW_W), .BUBBLE_TNEW(BT_B), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i),
      .instr_i(instr_i), .payload_i(payload_i), .newjudge_i(newjudge_i),
      .tnew_i(tnew_i), .cnt_clr(cnt_clr),
      .valid_o(b_valid), .instr_o(b_instr), .payload_o(b_payload),
      .newjudge_o(b_nj), .tnew_o(b_tnew), .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
   );

   always #5 clk = ~clk;

   // Reference state: what the downstream stage should currently see.
   bit            m_valid;
   logic [31:0]   m_instr;
   logic [PW-1:0] m_payload;
   bit            m_nj;
   int            m_tnew;
   int            m_stall;
   int            m_flush;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_valid   = 1'b0;
      m_instr   = '0;
      m_payload = '0;
      m_nj      = 1'b0;
      m_tnew    = 0;
      m_stall   = 0;
      m_flush   = 0;
   endtask

   task automatic model_edge();
      if (!reset) begin
         model_reset();
      end else begin
         if (cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
         end else begin
            if (!flush && !en && m_valid) m_stall++;
            if (flush && (valid_i || m_valid)) m_flush++;
         end
         if (flush || (en && !valid_i)) begin
            m_valid   = 1'b0;
            m_instr   = '0;
            m_payload = '0;
            m_nj      = 1'b0;
         end else if (en) begin
            m_valid   = 1'b1;
            m_instr   = instr_i;
            m_payload = payload_i;
            m_nj      = newjudge_i;
            m_tnew    = (int'(tnew_i) > 0) ? int'(tnew_i) - 1 : 0;
         end
      end
   endtask

   task automatic compare_all();
      check("valid_o", a_valid, m_valid);
      check("instr_o", a_instr, m_instr);
      check("payload_o", a_payload, m_payload);
      check("newjudge_o", a_nj, m_nj);
      check("tnew_o", a_tnew, m_valid ? m_tnew : BT_A);
      check("stall_cnt_o", a_stall, PERF ? sat(m_stall, 16) : 0);
      check("flush_cnt_o", a_flush, PERF ? sat(m_flush, 16) : 0);
      check("w4_valid_o", b_valid, m_valid);
      check("w4_tnew_o", b_tnew, m_valid ? m_tnew : BT_B);
      check("w4_stall_cnt_o", b_stall, PERF ? sat(m_stall, 4) : 0);
      check("w4_flush_cnt_o", b_flush, PERF ? sat(m_flush, 4) : 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic drive(input bit f, input bit e, input bit v, input logic [31:0] ins,
                        input int tn, input bit clr);
      flush      = f;
      en         = e;
      valid_i    = v;
      instr_i    = ins;
      tnew_i     = TNEW_W'(tn);
      cnt_clr    = clr;
      newjudge_i = 1'($urandom);
      for (int k = 0; k < N_WORDS; k++) payload_i[32*k +: 32] = $urandom;
   endtask

   int f_before;

   initial begin
      model_reset();
      #1 reset = 1'b0;
      #2 compare_all();
      tick();
      tick();
      reset = 1'b1;

      // Plain load
      drive(0, 1, 1, 32'h8C080004, 2, 0);
      tick();
      check("load_instr", a_instr, 32'h8C080004);
      check("load_valid", a_valid, 1'b1);
      check("load_tnew", a_tnew, 3'd1);

      // Tnew of zero must not wrap
      drive(0, 1, 1, $urandom, 0, 0);
      tick();
      check("tnew_floor", a_tnew, 3'd0);

      // Three-cycle stall after a fresh load with counters cleared
      drive(0, 1, 1, $urandom, 5, 1);
      tick();
      drive(0, 0, 1, $urandom, 7, 0);
      repeat (3) tick();
      check("stall_tnew_held", a_tnew, 3'd4);
      check("stall_cnt3", a_stall, PERF ? 3 : 0);

      // Flush beats enable
      f_before = m_flush;
      drive(1, 1, 1, 32'h24010005, 3, 0);
      tick();
      check("flush_valid", a_valid, 1'b0);
      check("flush_instr", a_instr, 32'h0);
      check("flush_tnew", a_tnew, BT_A);
      check("flush_cnt_inc", a_flush, PERF ? f_before + 1 : 0);

      // Asynchronous reset between edges while holding a real instruction
      drive(0, 1, 1, $urandom, 6, 0);
      tick();
      #1 reset = 1'b0;
      model_reset();
      #1;
      check("async_valid", a_valid, 1'b0);
      check("async_payload", a_payload, '0);
      compare_all();
      tick();
      reset = 1'b1;
      drive(0, 1, 1, 32'h8C080004, 2, 0);
      tick();
      check("post_rst_instr", a_instr, 32'h8C080004);
      check("post_rst_tnew", a_tnew, 3'd1);

      // Narrow counter saturates, then clear wins over a concurrent stall
      drive(0, 1, 1, $urandom, 3, 1);
      tick();
      drive(0, 0, 0, $urandom, 0, 0);
      repeat (20) tick();
      check("w4_stall_sat", b_stall, PERF ? 15 : 0);
      check("w16_stall_20", a_stall, PERF ? 20 : 0);
      drive(0, 0, 0, $urandom, 0, 1);
      tick();
      check("w4_clr", b_stall, 4'd0);
      check("w16_clr", a_stall, 16'd0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom % 8 == 0), 1'($urandom % 4 != 0), 1'($urandom % 4 != 0),
               $urandom, int'($urandom % 8), 1'($urandom % 40 == 0));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
